mem_ctrl: RTL
=============

// Module: mem_ctrl
// PURPOSE
// - Sole owner of the byte-serial unified RAM port. Sits downstream of fetcher (instr reads), LSB (loads) and ROB commit (stores).
// - Latches one request per client, grants one at a time, sequences 1/2/4 byte transfers, sign/zero-extends loads.
// - Returns a one-cycle done pulse with data to the granted client.
// PARAMETERS
// - IO_ADDR_HI   2'b11   value of addr[17:16] identifying the memory-mapped IO window
// - FETCH_BYTES  4       bytes per instruction fetch
// PORTS
// - clk             in   1   clock
// - rst             in   1   reset, synchronous, active-high
// - rdy             in   1   global enable; low => all state frozen, outputs held
// - in_flush        in   1   ROB misprediction flush
// - in_fetcher_ce   in   1   fetch request pulse
// - in_fetcher_addr in   32  fetch PC
// - out_fetcher_ce  out  1   fetch done pulse
// - out_fetcher_inst out 32  fetched instruction, little-endian
// - in_lsb_ce       in   1   load request pulse
// - in_lsb_size     in   3   1/2/4 bytes
// - in_lsb_signed   in   1   1 = sign-extend
// - in_lsb_addr     in   32  load address
// - out_lsb_ce      out  1   load done pulse
// - out_lsb_data    out  32  extended load data
// - in_rob_ce       in   1   committed-store request pulse
// - in_rob_size     in   3   1/2/4 bytes
// - in_rob_addr     in   32  store address
// - in_rob_data     in   32  store data (low bytes used)
// - out_rob_ce      out  1   store done pulse
// - mem_din         in   8   RAM read byte
// - mem_dout        out  8   RAM write byte
// - mem_a           out  32  RAM byte address
// - mem_wr          out  1   1 = write
// - io_buffer_full  in   1   UART FIFO full
// BEHAVIOUR
// - Reset: all outputs 0, FSM IDLE, all pending flags cleared.
// - Each client has a pending slot (valid, addr, size, signed/data). A request pulse sets it; a client must not re-request before its done.
// - Grant priority in IDLE: ROB store > LSB load > fetch. A request arriving in the same cycle as IDLE is grantable that cycle.
// - RAM timing: read byte for mem_a in cycle t is on mem_din in cycle t+1. mem_a, mem_wr, mem_dout are registered.
// - FSM: IDLE -> READ (fetch/load) or WRITE (store) -> IDLE. Byte counter is 0..size-1, little-endian.
// - READ, grant in cycle T:
//   - mem_a = A+k in cycle T+1+k.
//   - Byte k is captured in cycle T+2+k.
//   - Done pulse and data are visible in cycle T+size+2. Fetch: out_fetcher_ce in T+6.
// - WRITE: mem_wr=1, mem_a=A+k, mem_dout=data[8k+7:8k] in cycle T+1+k. out_rob_ce is visible in cycle T+size+1.
// - IO stall: if addr[17:16]==IO_ADDR_HI and io_buffer_full=1 when a byte is due, drive mem_wr=0 for that cycle, hold the counter, retry next cycle.
// - Load extension:
//   - size 1: signed => {{24{b0[7]}},b0}, else zero-extend.
//   - size 2: same rule on bit 15.
//   - size 4: raw.
// - Idle cycles: mem_wr=0 and mem_a holds its last value.
// - Flush:
//   - Clears fetch and load pending slots.
//   - Aborts an in-flight READ: return to IDLE next cycle, no done pulse.
//   - An in-flight or pending store is unaffected; it always completes.
//   - Flush in the same cycle as a new fetch/load pulse drops that pulse.
// - Done pulses are exactly 1 cycle. Data outputs hold until the next done.
// - rst mid-transfer: immediate IDLE, mem_wr=0 next cycle, all slots cleared.
// STRUCTURE
// - Shared constant.v: DATA_WIDTH, TRUE/FALSE, ZERO_DATA, MEM state encodings (IDLE/READ/WRITE), client-id encoding.
// - Single module; request slots are small register groups.
// - Optional sub-module mem_ext (combinational size/sign extension), shared by load return.
// TESTING
// - Fetch 0x1000, RAM bytes 13 05 00 00 -> out_fetcher_ce in T+6, inst 0x00000513; mem_a 0x1000..0x1003.
// - LB signed at 0x20, byte 0x80 -> out_lsb_data 0xFFFFFF80. LHU at 0x20, bytes 80 FF -> 0x0000FF80.
// - Store SW 0x11223344 to 0x40 and load LW in the same cycle -> store first (mem_wr bytes 44,33,22,11), then load returns 0x11223344.
// - SB to 0x30000 with io_buffer_full high 3 cycles -> mem_wr stays 0 for 3 cycles, then 1 write, out_rob_ce 1 cycle later.
// - Flush during fetch byte 2 -> no out_fetcher_ce, IDLE next cycle. Next pending store proceeds normally.
// - rdy low for 2 cycles mid-LW -> transfer stretches by exactly 2 cycles, data correct.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : mem_ctrl_pkg
//  Purpose : Shared constants, state/client encodings and small helpers for
//            the unified byte-serial RAM port controller.
//  Ports   : (package, none)
//  Rev     : 1.0  initial release
// ============================================================================
package mem_ctrl_pkg;

    localparam int                    DATA_WIDTH = 32;
    localparam logic                  TRUE       = 1'b1;
    localparam logic                  FALSE      = 1'b0;
    localparam logic [DATA_WIDTH-1:0] ZERO_DATA  = '0;

    typedef enum logic [1:0] {
        MEM_IDLE  = 2'd0,
        MEM_READ  = 2'd1,
        MEM_WRITE = 2'd2
    } mem_state_t;

    typedef enum logic [1:0] {
        CLI_NONE  = 2'd0,
        CLI_FETCH = 2'd1,
        CLI_LSB   = 2'd2,
        CLI_ROB   = 2'd3
    } client_t;

    // Byte lane 'idx' of a little-endian word.
    function automatic logic [7:0] byte_lane(input logic [DATA_WIDTH-1:0] data,
                                             input logic [1:0]            idx);
        return data[{idx, 3'b000} +: 8];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_ctrl_ext.sv
`default_nettype none
// ============================================================================
//  Module  : mem_ctrl_ext
//  Purpose : Combinational size/sign extension of assembled load data.
//  Ports   : raw       in  32  little-endian assembled bytes
//            size      in  3   1/2/4 bytes
//            is_signed in  1   1 = sign-extend from the top loaded bit
//            data      out 32  extended result
//  Rev     : 1.0  initial release
// ============================================================================
module mem_ctrl_ext
    import mem_ctrl_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] raw,
    input  logic [2:0]            size,
    input  logic                  is_signed,
    output logic [DATA_WIDTH-1:0] data
);

    always_comb begin
        data = raw;
        case (size)
            3'd1:    data = {{24{is_signed & raw[7]}},  raw[7:0]};
            3'd2:    data = {{16{is_signed & raw[15]}}, raw[15:0]};
            default: data = raw;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : mem_ctrl
//  Purpose : Sole owner of the byte-serial RAM port. Latches one request per
//            client (fetch, load, committed store), grants one at a time
//            (store > load > fetch), sequences 1/2/4-byte transfers and
//            returns a one-cycle done pulse with data.
//  Ports   : clk, rst (sync, active-high), rdy (global enable), in_flush
//            fetch  : in_fetcher_ce/addr  -> out_fetcher_ce/inst
//            load   : in_lsb_ce/size/signed/addr -> out_lsb_ce/data
//            store  : in_rob_ce/size/addr/data   -> out_rob_ce
//            RAM    : mem_din in, mem_dout/mem_a/mem_wr out (registered)
//            io_buffer_full : UART FIFO full, stalls IO-window writes
//  Rev     : 1.0  initial release
// ============================================================================
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter logic [1:0] IO_ADDR_HI  = 2'b11,
    parameter int         FETCH_BYTES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        in_flush,
    input  logic        in_fetcher_ce,
    input  logic [31:0] in_fetcher_addr,
    output logic        out_fetcher_ce,
    output logic [31:0] out_fetcher_inst,
    input  logic        in_lsb_ce,
    input  logic [2:0]  in_lsb_size,
    input  logic        in_lsb_signed,
    input  logic [31:0] in_lsb_addr,
    output logic        out_lsb_ce,
    output logic [31:0] out_lsb_data,
    input  logic        in_rob_ce,
    input  logic [2:0]  in_rob_size,
    input  logic [31:0] in_rob_addr,
    input  logic [31:0] in_rob_data,
    output logic        out_rob_ce,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    localparam logic [2:0] c_fetch_size = 3'(FETCH_BYTES);

    mem_state_t  r_state;
    client_t     r_client;
    logic [2:0]  r_cnt, r_size;
    logic [31:0] r_addr, r_wdata, r_buf;
    logic        r_signed;
    logic [7:0]  r_din_save;
    logic        r_rdy_d;

    // Request slots
    logic        r_f_valid;
    logic [31:0] r_f_addr;
    logic        r_l_valid, r_l_signed;
    logic [2:0]  r_l_size;
    logic [31:0] r_l_addr;
    logic        r_s_valid;
    logic [2:0]  r_s_size;
    logic [31:0] r_s_addr, r_s_data;

    client_t     w_grant;
    logic [31:0] w_g_addr, w_g_data, w_assembled, w_ext;
    logic [2:0]  w_g_size;
    logic        w_g_signed, w_stall_grant, w_stall_write;
    logic [7:0]  w_byte_in;

    // Grant selection: a pulse arriving this cycle is as good as a latched slot.
    // Flush suppresses fetch/load candidates so they are never granted.
    always_comb begin
        w_grant    = CLI_NONE;
        w_g_addr   = ZERO_DATA;
        w_g_data   = ZERO_DATA;
        w_g_size   = 3'd0;
        w_g_signed = FALSE;
        if (r_s_valid || in_rob_ce) begin
            w_grant  = CLI_ROB;
            w_g_addr = r_s_valid ? r_s_addr : in_rob_addr;
            w_g_size = r_s_valid ? r_s_size : in_rob_size;
            w_g_data = r_s_valid ? r_s_data : in_rob_data;
        end else if (!in_flush && (r_l_valid || in_lsb_ce)) begin
            w_grant    = CLI_LSB;
            w_g_addr   = r_l_valid ? r_l_addr   : in_lsb_addr;
            w_g_size   = r_l_valid ? r_l_size   : in_lsb_size;
            w_g_signed = r_l_valid ? r_l_signed : in_lsb_signed;
        end else if (!in_flush && (r_f_valid || in_fetcher_ce)) begin
            w_grant  = CLI_FETCH;
            w_g_addr = r_f_valid ? r_f_addr : in_fetcher_addr;
            w_g_size = c_fetch_size;
        end
    end

    assign w_stall_grant = (w_g_addr[17:16] == IO_ADDR_HI) && io_buffer_full;
    assign w_stall_write = (r_addr[17:16]   == IO_ADDR_HI) && io_buffer_full;

    // The RAM keeps answering while rdy is low, so after a pause mem_din
    // reflects the held address rather than the previous one. The byte seen in
    // the first paused cycle is saved and substituted on resume.
    assign w_byte_in = r_rdy_d ? mem_din : r_din_save;

    // r_cnt counts READ cycles; the byte arriving now belongs to lane r_cnt-1.
    always_comb begin
        w_assembled = r_buf;
        case (r_cnt)
            3'd1:    w_assembled[7:0]   = w_byte_in;
            3'd2:    w_assembled[15:8]  = w_byte_in;
            3'd3:    w_assembled[23:16] = w_byte_in;
            3'd4:    w_assembled[31:24] = w_byte_in;
            default: ;
        endcase
    end

    mem_ctrl_ext u_ext (
        .raw       (w_assembled),
        .size      (r_size),
        .is_signed (r_signed),
        .data      (w_ext)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= MEM_IDLE;   r_client <= CLI_NONE;
            r_cnt <= 3'd0;         r_size <= 3'd0;        r_signed <= FALSE;
            r_addr <= ZERO_DATA;   r_wdata <= ZERO_DATA;  r_buf <= ZERO_DATA;
            r_din_save <= 8'h00;   r_rdy_d <= TRUE;
            r_f_valid <= FALSE;    r_f_addr <= ZERO_DATA;
            r_l_valid <= FALSE;    r_l_addr <= ZERO_DATA;
            r_l_size <= 3'd0;      r_l_signed <= FALSE;
            r_s_valid <= FALSE;    r_s_addr <= ZERO_DATA;
            r_s_size <= 3'd0;      r_s_data <= ZERO_DATA;
            out_fetcher_ce <= FALSE; out_fetcher_inst <= ZERO_DATA;
            out_lsb_ce <= FALSE;     out_lsb_data <= ZERO_DATA;
            out_rob_ce <= FALSE;
            mem_dout <= 8'h00;     mem_a <= ZERO_DATA;    mem_wr <= FALSE;
        end else if (!rdy) begin
            if (r_rdy_d) r_din_save <= mem_din;
            r_rdy_d <= FALSE;
        end else begin
            r_rdy_d        <= TRUE;
            out_fetcher_ce <= FALSE;
            out_lsb_ce     <= FALSE;
            out_rob_ce     <= FALSE;

            // Slot capture; a grant below in the same cycle overrides the set.
            if (in_rob_ce) begin
                r_s_valid <= TRUE;  r_s_addr <= in_rob_addr;
                r_s_size <= in_rob_size; r_s_data <= in_rob_data;
            end
            if (in_lsb_ce && !in_flush) begin
                r_l_valid <= TRUE;  r_l_addr <= in_lsb_addr;
                r_l_size <= in_lsb_size; r_l_signed <= in_lsb_signed;
            end
            if (in_fetcher_ce && !in_flush) begin
                r_f_valid <= TRUE;  r_f_addr <= in_fetcher_addr;
            end
            if (in_flush) begin
                r_l_valid <= FALSE;
                r_f_valid <= FALSE;
            end

            case (r_state)
                MEM_IDLE: begin
                    mem_wr   <= FALSE;
                    r_client <= w_grant;
                    r_addr   <= w_g_addr;
                    r_size   <= w_g_size;
                    r_signed <= w_g_signed;
                    r_wdata  <= w_g_data;
                    r_buf    <= ZERO_DATA;
                    case (w_grant)
                        CLI_ROB: begin
                            r_s_valid <= FALSE;
                            r_state   <= MEM_WRITE;
                            if (w_stall_grant) begin
                                r_cnt <= 3'd0;
                            end else begin
                                mem_wr   <= TRUE;
                                mem_a    <= w_g_addr;
                                mem_dout <= w_g_data[7:0];
                                r_cnt    <= 3'd1;
                            end
                        end
                        CLI_LSB, CLI_FETCH: begin
                            if (w_grant == CLI_LSB) r_l_valid <= FALSE;
                            else                    r_f_valid <= FALSE;
                            r_state <= MEM_READ;
                            mem_a   <= w_g_addr;
                            r_cnt   <= 3'd0;
                        end
                        default: ;
                    endcase
                end

                MEM_READ: begin
                    if (in_flush) begin
                        r_state <= MEM_IDLE;
                    end else if (r_cnt == r_size) begin
                        r_state <= MEM_IDLE;
                        if (r_client == CLI_FETCH) begin
                            out_fetcher_ce   <= TRUE;
                            out_fetcher_inst <= w_assembled;
                        end else begin
                            out_lsb_ce   <= TRUE;
                            out_lsb_data <= w_ext;
                        end
                    end else begin
                        r_buf <= w_assembled;
                        if (3'(r_cnt + 3'd1) < r_size)
                            mem_a <= r_addr + 32'(r_cnt) + 32'd1;
                        r_cnt <= r_cnt + 3'd1;
                    end
                end

                MEM_WRITE: begin
                    if (r_cnt == r_size) begin
                        mem_wr     <= FALSE;
                        out_rob_ce <= TRUE;
                        r_state    <= MEM_IDLE;
                    end else if (w_stall_write) begin
                        mem_wr <= FALSE;
                    end else begin
                        mem_wr   <= TRUE;
                        mem_a    <= r_addr + 32'(r_cnt);
                        mem_dout <= byte_lane(r_wdata, r_cnt[1:0]);
                        r_cnt    <= r_cnt + 3'd1;
                    end
                end

                default: r_state <= MEM_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
